// File: rtl/trap_ctrl_pkg.sv
// Shared cause codes and FSM encoding for the trap producer.
// No logic; constants only.
package trap_ctrl_pkg;

    localparam logic [4:0] EX_INSTR_MISALIGN = 5'd0;
    localparam logic [4:0] EX_INSTR_FAULT    = 5'd1;
    localparam logic [4:0] EX_ILLEGAL        = 5'd2;
    localparam logic [4:0] EX_BREAKPOINT     = 5'd3;
    localparam logic [4:0] EX_LOAD_MISALIGN  = 5'd4;
    localparam logic [4:0] EX_LOAD_FAULT     = 5'd5;
    localparam logic [4:0] EX_STORE_MISALIGN = 5'd6;
    localparam logic [4:0] EX_STORE_FAULT    = 5'd7;
    localparam logic [4:0] EX_ECALL_M        = 5'd11;
    localparam logic [4:0] IRQ_EXT_M         = 5'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } trap_state_t;

endpackage

// File: rtl/trap_ctrl_prio_sel.sv
// Purpose: pick the architecturally oldest exception source (mem > id > if > irq).
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the selection is consumed.
module trap_prio_sel
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EX_W = 5
) (
    input  logic            if_ex_valid,
    input  logic [EX_W-1:0] if_ex_code,
    input  logic [XLEN-1:0] if_pc,
    input  logic            id_ex_valid,
    input  logic [EX_W-1:0] id_ex_code,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_instr,
    input  logic            mem_ex_valid,
    input  logic [EX_W-1:0] mem_ex_code,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            irq_pending,
    input  logic            irq_enable,
    output logic            sel_vld,
    output logic [EX_W-1:0] sel_code,
    output logic            sel_irq,
    output logic [XLEN-1:0] sel_pc,
    output logic [XLEN-1:0] sel_tval
);

    always_comb begin
        sel_vld  = 1'b0;
        sel_code = '0;
        sel_irq  = 1'b0;
        sel_pc   = '0;
        sel_tval = '0;
        if (mem_ex_valid) begin
            sel_vld  = 1'b1;
            sel_code = mem_ex_code;
            sel_pc   = mem_pc;
            sel_tval = mem_addr;
        end else if (id_ex_valid) begin
            sel_vld  = 1'b1;
            sel_code = id_ex_code;
            sel_pc   = id_pc;
            // Only illegal-instruction reports carry the raw encoding in mtval.
            sel_tval = (id_ex_code == EX_W'(EX_ILLEGAL)) ? id_instr : '0;
        end else if (if_ex_valid) begin
            sel_vld  = 1'b1;
            sel_code = if_ex_code;
            sel_pc   = if_pc;
            sel_tval = if_pc;
        end else if (irq_pending && irq_enable) begin
            // Interrupt is charged to the next instruction due to retire.
            sel_vld  = 1'b1;
            sel_code = EX_W'(IRQ_EXT_M);
            sel_irq  = 1'b1;
            sel_pc   = id_pc;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Purpose: arbitrate pipeline exception reports and IRQ into one registered trap pulse.
// Latency: report sampled at edge N -> exception_valid during the following cycle.
// Backpressure: none inbound; reports are dropped while stalled (TRAP/DRAIN), stall freezes front end.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int EX_W         = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_ex_valid,
    input  logic [EX_W-1:0] if_ex_code,
    input  logic [XLEN-1:0] if_pc,
    input  logic            id_ex_valid,
    input  logic [EX_W-1:0] id_ex_code,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_instr,
    input  logic            mem_ex_valid,
    input  logic [EX_W-1:0] mem_ex_code,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            irq_pending,
    input  logic            irq_enable,
    output logic            exception_valid,
    output logic [EX_W-1:0] exception,
    output logic            exception_irq,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] trap_tval,
    output logic            stall
);

    trap_state_t     state;
    logic [3:0]      drain_cnt;
    logic            sel_vld;
    logic [EX_W-1:0] sel_code;
    logic            sel_irq;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_tval;
    logic            take;

    trap_prio_sel #(.XLEN(XLEN), .EX_W(EX_W)) u_prio (
        .if_ex_valid (if_ex_valid),
        .if_ex_code  (if_ex_code),
        .if_pc       (if_pc),
        .id_ex_valid (id_ex_valid),
        .id_ex_code  (id_ex_code),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .mem_ex_valid(mem_ex_valid),
        .mem_ex_code (mem_ex_code),
        .mem_pc      (mem_pc),
        .mem_addr    (mem_addr),
        .irq_pending (irq_pending),
        .irq_enable  (irq_enable),
        .sel_vld     (sel_vld),
        .sel_code    (sel_code),
        .sel_irq     (sel_irq),
        .sel_pc      (sel_pc),
        .sel_tval    (sel_tval)
    );

    // The last drain cycle also samples, so held reports re-trap every DRAIN_CYCLES+1 cycles.
    assign take = sel_vld && ((state == IDLE) || ((state == DRAIN) && (drain_cnt == 4'd0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            drain_cnt       <= 4'd0;
            exception_valid <= 1'b0;
            exception       <= '0;
            exception_irq   <= 1'b0;
            trap_pc         <= '0;
            trap_tval       <= '0;
            stall           <= 1'b0;
        end else if (take) begin
            state           <= TRAP;
            exception_valid <= 1'b1;
            stall           <= 1'b1;
            exception       <= sel_code;
            exception_irq   <= sel_irq;
            trap_pc         <= sel_pc;
            trap_tval       <= sel_tval;
        end else begin
            case (state)
                IDLE: begin
                    exception_valid <= 1'b0;
                    stall           <= 1'b0;
                end
                TRAP: begin
                    state           <= DRAIN;
                    drain_cnt       <= 4'(DRAIN_CYCLES - 1);
                    exception_valid <= 1'b0;
                end
                DRAIN: begin
                    if (drain_cnt != 4'd0) begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end else begin
                        state         <= IDLE;
                        stall         <= 1'b0;
                        exception     <= '0;
                        exception_irq <= 1'b0;
                        trap_pc       <= '0;
                        trap_tval     <= '0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    exception_valid <= 1'b0;
                    stall           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboarded bench for trap_ctrl: edge-based reference model plus a negedge monitor.
module tb_trap_ctrl;

    localparam int XLEN = 32;
    localparam int EX_W = 5;
    localparam int D    = 3;

    typedef struct {
        int          edge_n;
        logic        vld;
        logic [4:0]  code;
        logic        irq;
        logic [31:0] pc;
        logic [31:0] tval;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_ex_valid, id_ex_valid, mem_ex_valid;
    logic [EX_W-1:0] if_ex_code, id_ex_code, mem_ex_code;
    logic [XLEN-1:0] if_pc, id_pc, id_instr, mem_pc, mem_addr;
    logic            irq_pending, irq_enable;
    logic            exception_valid, exception_irq, stall;
    logic [EX_W-1:0] exception;
    logic [XLEN-1:0] trap_pc, trap_tval;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;
    int   stall_until = -1;
    int   next_ok = 0;
    int   pulse_cnt = 0;
    exp_t sb[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .EX_W(EX_W), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .if_ex_valid(if_ex_valid), .if_ex_code(if_ex_code), .if_pc(if_pc),
        .id_ex_valid(id_ex_valid), .id_ex_code(id_ex_code), .id_pc(id_pc), .id_instr(id_instr),
        .mem_ex_valid(mem_ex_valid), .mem_ex_code(mem_ex_code), .mem_pc(mem_pc), .mem_addr(mem_addr),
        .irq_pending(irq_pending), .irq_enable(irq_enable),
        .exception_valid(exception_valid), .exception(exception), .exception_irq(exception_irq),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .stall(stall)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Oldest-first choice among the reports visible at this edge.
    function automatic exp_t pick();
        exp_t w = '{default: 0};
        if (mem_ex_valid) begin
            w.vld = 1; w.code = mem_ex_code; w.pc = mem_pc; w.tval = mem_addr;
        end else if (id_ex_valid) begin
            w.vld = 1; w.code = id_ex_code; w.pc = id_pc;
            w.tval = (id_ex_code == 5'd2) ? id_instr : 32'd0;
        end else if (if_ex_valid) begin
            w.vld = 1; w.code = if_ex_code; w.pc = if_pc; w.tval = if_pc;
        end else if (irq_pending && irq_enable) begin
            w.vld = 1; w.code = 5'd11; w.irq = 1; w.pc = id_pc; w.tval = 32'd0;
        end
        return w;
    endfunction

    // Reference model: a trap taken at edge N blocks sampling until edge N+D+1.
    always @(posedge clk) begin
        exp_t w;
        edge_cnt++;
        if (reset) begin
            sb.delete();
            stall_until = -1;
            next_ok     = edge_cnt + 1;
        end else if (edge_cnt >= next_ok) begin
            w = pick();
            if (w.vld) begin
                w.edge_n    = edge_cnt;
                sb.push_back(w);
                stall_until = edge_cnt + D;
                next_ok     = edge_cnt + D + 1;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic exp_stall;
        logic exp_pulse;
        if (edge_cnt > 0) begin
            exp_stall = (edge_cnt <= stall_until);
            exp_pulse = (sb.size() > 0) && (sb[0].edge_n == edge_cnt);
            chk("stall", 72'(stall), 72'(exp_stall));
            if (exception_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                pulse_cnt++;
                chk("pulse_edge", 72'(edge_cnt), 72'(e.edge_n));
                chk("cause", 72'({exception_irq, exception}), 72'({e.irq, e.code}));
                chk("trap_pc", 72'(trap_pc), 72'(e.pc));
                chk("trap_tval", 72'(trap_tval), 72'(e.tval));
                last_exp = e;
            end else begin
                chk("exception_valid", 72'(exception_valid), 72'(exp_pulse));
                if (exp_pulse) void'(sb.pop_front());
                if (!exp_stall)
                    chk("idle_outputs", 72'({exception_irq, exception, trap_pc, trap_tval}), 72'd0);
                else
                    chk("held_outputs", 72'({exception_irq, exception, trap_pc, trap_tval}),
                        72'({last_exp.irq, last_exp.code, last_exp.pc, last_exp.tval}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        if_ex_valid = 0; id_ex_valid = 0; mem_ex_valid = 0;
    endtask

    task automatic idle(input int n);
        clear();
        repeat (n) step();
    endtask

    initial begin
        int base;
        last_exp = '{default: 0};
        reset = 1; irq_pending = 0; irq_enable = 0; clear();
        if_ex_code = 0; id_ex_code = 0; mem_ex_code = 0;
        if_pc = 0; id_pc = 0; id_instr = 0; mem_pc = 0; mem_addr = 0;
        repeat (3) step();
        reset = 0;
        idle(2);

        // Illegal instruction in decode.
        id_ex_valid = 1; id_ex_code = 5'd2; id_pc = 32'h100; id_instr = 32'hFFFF_FFFF;
        step();
        idle(6);

        // All three synchronous sources at once: mem wins.
        mem_ex_valid = 1; mem_ex_code = 5'd5; mem_pc = 32'h200; mem_addr = 32'h8000_0004;
        id_ex_valid = 1; id_ex_code = 5'd2; if_ex_valid = 1; if_ex_code = 5'd1; if_pc = 32'h300;
        step();
        idle(6);

        // Masked then enabled interrupt.
        irq_pending = 1; irq_enable = 0;
        repeat (5) step();
        irq_enable = 1; id_pc = 32'h40;
        step();
        irq_pending = 0;
        idle(6);

        // Memory report during drain is dropped.
        id_ex_valid = 1; id_ex_code = 5'd3; id_pc = 32'h500;
        step();
        idle(2);
        mem_ex_valid = 1; mem_ex_code = 5'd7; mem_pc = 32'h600; mem_addr = 32'h1234;
        step();
        idle(6);

        // Reset while in TRAP, then a fresh report.
        id_ex_valid = 1; id_ex_code = 5'd11; id_pc = 32'h700;
        step();
        clear(); reset = 1;
        step();
        reset = 0;
        id_ex_valid = 1; id_ex_code = 5'd2; id_pc = 32'h704; id_instr = 32'hDEAD_BEEF;
        step();
        idle(6);

        // Continuously held report re-traps every D+1 cycles.
        base = pulse_cnt;
        if_ex_valid = 1; if_ex_code = 5'd0; if_pc = 32'h802;
        repeat (16) step();
        idle(6);
        chk("held_pulse_count", 72'(pulse_cnt - base), 72'(16 / (D + 1)));

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            if_ex_valid  = ($urandom_range(0, 7) == 0);
            id_ex_valid  = ($urandom_range(0, 7) == 0);
            mem_ex_valid = ($urandom_range(0, 9) == 0);
            if_ex_code   = 5'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: id_ex_code = 5'd2;
                1: id_ex_code = 5'd3;
                default: id_ex_code = 5'd11;
            endcase
            mem_ex_code  = 5'($urandom_range(4, 7));
            if_pc = $urandom; id_pc = $urandom; id_instr = $urandom;
            mem_pc = $urandom; mem_addr = $urandom;
            if ($urandom_range(0, 15) == 0) irq_pending = ~irq_pending;
            if ($urandom_range(0, 15) == 0) irq_enable = ~irq_enable;
            step();
        end
        reset = 0; irq_pending = 0;
        idle(8);
        chk("scoreboard_drained", 72'(sb.size()), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
